sgm_agg_line_buffer: RTL and testbench

- Parametrised, self-contained line buffer for SGM path aggregation.
- Stores the previous row's aggregated cost vectors in an inferred dual-port RAM.
- Presents a 3-column window (x-1, x, x+1) of the previous row for every accepted pixel. This lets a single buffer feed the 45°, 90° and 135° path units, instead of one RAM per direction.
- Owns its own address generation, row sequencing, read/write hazard ordering, edge flags and runtime disparity masking. It sits between the cost-aggregation datapath and disparity selection inside the disparity-map top.

---
 rtl/sgm_agg_line_buffer_if.sv | 35 +++
 rtl/sgm_agg_line_buffer.sv | 178 +++++++++++++++++
 tb/tb_sgm_agg_line_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sgm_agg_line_buffer_if.sv
// Pixel/write handshakes and previous-row window bus of the SGM aggregation line buffer.
// The slave modport is the buffer itself; master is the aggregation datapath side.
interface sgm_agg_line_buffer_if #(
    parameter int NUM_DISP = 128,
    parameter int COST_W   = 9
);
    localparam int DATA_W = NUM_DISP * COST_W;

    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_lo;
    logic [DATA_W-1:0] out_mid;
    logic [DATA_W-1:0] out_hi;
    logic              out_lo_ok;
    logic              out_hi_ok;
    logic              out_first_row;
    logic              frame_done;

    modport master (
        output in_valid, in_sof, wr_valid, wr_data,
        input  in_ready, wr_ready, out_valid, out_lo, out_mid, out_hi,
               out_lo_ok, out_hi_ok, out_first_row, frame_done
    );

    modport slave (
        input  in_valid, in_sof, wr_valid, wr_data,
        output in_ready, wr_ready, out_valid, out_lo, out_mid, out_hi,
               out_lo_ok, out_hi_ok, out_first_row, frame_done
    );
endinterface

// File: rtl/sgm_agg_line_buffer.sv
// Previous-row line buffer for SGM path aggregation: one RAM feeding a 3-column
// (x-1, x, x+1) window to the 45/90/135 degree path units, with disparity masking.
module sgm_agg_line_buffer #(
    parameter int NUM_DISP  = 128,
    parameter int COST_W    = 9,
    parameter int MAX_WIDTH = 1920,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_width,
    input  logic [ADDR_W-1:0] cfg_height,
    input  logic [8:0]        cfg_range,
    sgm_agg_line_buffer_if.slave bus
);
    localparam int DATA_W = NUM_DISP * COST_W;
    localparam logic [ADDR_W-1:0] MAX_W = ADDR_W'(MAX_WIDTH);
    localparam logic [ADDR_W-1:0] MIN_W = ADDR_W'(2);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, PREFETCH} state_t;
    state_t state;

    logic [ADDR_W-1:0] width_q, height_q, col, wr_col, row;
    logic [8:0]        range_q;
    logic [DATA_W-1:0] mem [MAX_WIDTH];
    logic [DATA_W-1:0] rd_data, win_mid, win_hi, hi_vec, lane_force;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en, sof_acc, pix_acc, wr_acc, last_pix, pf_q;
    logic              p1_vld, p1_lo_ok, p1_hi_ok, p1_first;

    assign sof_acc  = (state == IDLE) && bus.in_valid && bus.in_sof && bus.in_ready;
    assign pix_acc  = (state == ACTIVE) && bus.in_valid && bus.in_ready;
    assign last_pix = (col == width_q - ADDR_W'(1));

    // A column is overwritten only after its previous-row value has been read.
    assign bus.wr_ready = ((state == ACTIVE) && (wr_col < col)) ||
                          ((state == DRAIN) && (wr_col < width_q));
    assign wr_acc = bus.wr_valid && bus.wr_ready;

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (sof_acc) begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(1);
        end else if (pix_acc && !last_pix) begin
            rd_en   = 1'b1;
            rd_addr = col + ADDR_W'(1);
        end else if (state == PREFETCH) begin
            rd_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_col] <= bus.wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            width_q        <= '0;
            height_q       <= '0;
            range_q        <= '0;
            col            <= '0;
            wr_col         <= '0;
            row            <= '0;
            pf_q           <= 1'b0;
            p1_vld         <= 1'b0;
            p1_lo_ok       <= 1'b0;
            p1_hi_ok       <= 1'b0;
            p1_first       <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            pf_q           <= 1'b0;
            p1_vld         <= 1'b0;
            if (wr_acc) wr_col <= wr_col + ADDR_W'(1);
            unique case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (sof_acc) begin
                        width_q  <= (cfg_width > MAX_W) ? MAX_W :
                                    (cfg_width < MIN_W) ? MIN_W : cfg_width;
                        height_q <= cfg_height;
                        range_q  <= cfg_range;
                        row      <= '0;
                        col      <= ADDR_W'(1);
                        wr_col   <= '0;
                        p1_vld   <= 1'b1;
                        p1_lo_ok <= 1'b0;
                        p1_hi_ok <= 1'b1;
                        p1_first <= 1'b1;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pix_acc) begin
                        col      <= col + ADDR_W'(1);
                        p1_vld   <= 1'b1;
                        p1_lo_ok <= (col != '0);
                        p1_hi_ok <= !last_pix;
                        p1_first <= (row == '0);
                        if (last_pix) begin
                            bus.in_ready <= 1'b0;
                            state        <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_col == width_q) begin
                        if (row == height_q - ADDR_W'(1)) begin
                            bus.frame_done <= 1'b1;
                            bus.in_ready   <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            row    <= row + ADDR_W'(1);
                            wr_col <= '0;
                            col    <= '0;
                            state  <= PREFETCH;
                        end
                    end
                end
                PREFETCH: begin
                    pf_q         <= 1'b1;
                    bus.in_ready <= 1'b1;
                    state        <= ACTIVE;
                end
            endcase
        end
    end

    always_comb begin
        lane_force = '0;
        for (int unsigned d = 0; d < NUM_DISP; d++) begin
            if (d >= 32'(range_q)) lane_force[d*COST_W +: COST_W] = '1;
        end
    end

    assign hi_vec = p1_hi_ok ? rd_data : '0;

    // win_mid/win_hi hold columns x-1/x ahead of each pixel; the prefetch result seeds x=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_mid           <= '0;
            win_hi            <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_lo        <= '0;
            bus.out_mid       <= '0;
            bus.out_hi        <= '0;
            bus.out_lo_ok     <= 1'b0;
            bus.out_hi_ok     <= 1'b0;
            bus.out_first_row <= 1'b0;
        end else begin
            bus.out_valid <= p1_vld;
            if (pf_q) begin
                win_mid <= '0;
                win_hi  <= rd_data;
            end else if (p1_vld) begin
                win_mid           <= win_hi;
                win_hi            <= hi_vec;
                bus.out_lo_ok     <= p1_lo_ok;
                bus.out_hi_ok     <= p1_hi_ok;
                bus.out_first_row <= p1_first;
                if (p1_first) begin
                    bus.out_lo  <= '0;
                    bus.out_mid <= '0;
                    bus.out_hi  <= '0;
                end else begin
                    bus.out_lo  <= (p1_lo_ok ? win_mid : '0) | lane_force;
                    bus.out_mid <= win_hi | lane_force;
                    bus.out_hi  <= hi_vec | lane_force;
                end
            end
        end
    end
endmodule

// File: tb/tb_sgm_agg_line_buffer.sv
// Directed bench for sgm_agg_line_buffer: table of expected windows per frame plus
// hand sequences for write hazard ordering and mid-frame reset.
module tb_sgm_agg_line_buffer;
    localparam int NUM_DISP = 128;
    localparam int COST_W   = 9;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = NUM_DISP * COST_W;
    localparam int NTBL     = 14;

    typedef struct {
        int frm; int row; int col;
        bit lo_ok; bit hi_ok; bit first;
        int rng; int lo; int mid; int hi;
    } vec_t;

    typedef struct { int cyc; int row; int col; } pend_t;

    typedef struct {
        int row; int col; int lat;
        bit lo_ok; bit hi_ok; bit first;
        logic [DATA_W-1:0] lo; logic [DATA_W-1:0] mid; logic [DATA_W-1:0] hi;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] cfg_width = '0;
    logic [ADDR_W-1:0] cfg_height = '0;
    logic [8:0]        cfg_range = '0;

    sgm_agg_line_buffer_if #(.NUM_DISP(NUM_DISP), .COST_W(COST_W)) bus ();

    sgm_agg_line_buffer #(
        .NUM_DISP(NUM_DISP), .COST_W(COST_W), .MAX_WIDTH(1920), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_range(cfg_range),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int fw, fh, cval, pr, pc, wr_r, wr_c;
    int stop_r, stop_c, fd_cnt, drain_wr, n_spur, t_last0, t_first1;
    bit hold, hit_stop;
    pend_t pend[$];
    obs_t  obs[$];
    vec_t  tbl [NTBL];

    function automatic logic [DATA_W-1:0] mk(input int v, input int rng);
        logic [DATA_W-1:0] r;
        for (int d = 0; d < NUM_DISP; d++)
            r[d*COST_W +: COST_W] = (d < rng) ? COST_W'(v) : '1;
        return r;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            int l = 0;
            for (int d = NUM_DISP - 1; d >= 0; d--)
                if (got[d*COST_W +: COST_W] !== exp[d*COST_W +: COST_W]) l = d;
            n_fail++;
            $display("FAIL %s: lane %0d got %h expected %h", nm, l,
                     got[l*COST_W +: COST_W], exp[l*COST_W +: COST_W]);
        end
    endtask

    // Sample outputs of the last edge, then drive inputs for the next edge.
    task automatic tick();
        pend_t p;
        obs_t  o;
        bit    pix_acc, wr_acc;
        @(negedge clk);
        cyc++;
        if (bus.out_valid) begin
            if (pend.size() == 0) begin
                n_spur++;
            end else begin
                p       = pend.pop_front();
                o.row   = p.row;
                o.col   = p.col;
                o.lat   = cyc - p.cyc;
                o.lo_ok = bus.out_lo_ok;
                o.hi_ok = bus.out_hi_ok;
                o.first = bus.out_first_row;
                o.lo    = bus.out_lo;
                o.mid   = bus.out_mid;
                o.hi    = bus.out_hi;
                obs.push_back(o);
            end
        end
        if (bus.frame_done) fd_cnt++;
        bus.in_valid = (pr < fh);
        bus.in_sof   = (pr == 0) && (pc == 0);
        bus.wr_valid = (wr_r < fh) && (!hold || pr > wr_r);
        bus.wr_data  = mk((cval < 0) ? 10 * wr_r + wr_c : cval, NUM_DISP);
        pix_acc = bus.in_valid && bus.in_ready;
        wr_acc  = bus.wr_valid && bus.wr_ready;
        if (wr_acc && !bus.in_ready) drain_wr++;
        if (pix_acc) begin
            pend.push_back(pend_t'{cyc, pr, pc});
            if (pr == 0 && pc == fw - 1) t_last0 = cyc;
            if (pr == 1 && pc == 0) t_first1 = cyc;
            if (pr == stop_r && pc == stop_c) hit_stop = 1'b1;
            pc++;
            if (pc == fw) begin pc = 0; pr++; end
        end
        if (wr_acc) begin
            wr_c++;
            if (wr_c == fw) begin wr_c = 0; wr_r++; end
        end
    endtask

    task automatic run_frame(input int w, input int h, input int rng, input bit hld,
                             input int cv, input int sr, input int sc, input int frm);
        obs_t o;
        bit   found;
        pend.delete();
        obs.delete();
        fw = w; fh = h; hold = hld; cval = cv; stop_r = sr; stop_c = sc;
        pr = 0; pc = 0; wr_r = 0; wr_c = 0;
        fd_cnt = 0; drain_wr = 0; n_spur = 0; t_last0 = 0; t_first1 = 0;
        hit_stop = 1'b0;
        cfg_width  = ADDR_W'(w);
        cfg_height = ADDR_W'(h);
        cfg_range  = 9'(rng);
        for (int n = 0; n < 400; n++) begin
            tick();
            if (fd_cnt != 0 || hit_stop) break;
        end
        if (sr >= 0) begin
            chk($sformatf("f%0d_stop_point_reached", frm), hit_stop, 1);
            return;
        end
        for (int n = 0; n < 4; n++) tick();
        chk($sformatf("f%0d_frame_done_pulses", frm), fd_cnt, 1);
        chk($sformatf("f%0d_out_count", frm), obs.size(), w * h);
        chk($sformatf("f%0d_spurious_out", frm), n_spur, 0);
        chk($sformatf("f%0d_idle_in_ready", frm), bus.in_ready, 1);
        foreach (obs[j])
            chk($sformatf("f%0d_r%0d_c%0d_latency", frm, obs[j].row, obs[j].col), obs[j].lat, 2);
        if (hld) begin
            chk($sformatf("f%0d_writes_while_stalled", frm), drain_wr, w * h);
            chk($sformatf("f%0d_row_gap_cycles", frm), t_first1 - t_last0, 7);
        end
        for (int i = 0; i < NTBL; i++) begin
            if (tbl[i].frm == frm) begin
                found = 1'b0;
                foreach (obs[j])
                    if (obs[j].row == tbl[i].row && obs[j].col == tbl[i].col) begin
                        o = obs[j];
                        found = 1'b1;
                    end
                chk($sformatf("f%0d_r%0d_c%0d_present", frm, tbl[i].row, tbl[i].col), found, 1);
                if (found) begin
                    chk($sformatf("f%0d_r%0d_c%0d_lo_ok", frm, o.row, o.col), o.lo_ok, tbl[i].lo_ok);
                    chk($sformatf("f%0d_r%0d_c%0d_hi_ok", frm, o.row, o.col), o.hi_ok, tbl[i].hi_ok);
                    chk($sformatf("f%0d_r%0d_c%0d_first_row", frm, o.row, o.col), o.first, tbl[i].first);
                    chkv($sformatf("f%0d_r%0d_c%0d_lo", frm, o.row, o.col), o.lo, mk(tbl[i].lo, tbl[i].rng));
                    chkv($sformatf("f%0d_r%0d_c%0d_mid", frm, o.row, o.col), o.mid, mk(tbl[i].mid, tbl[i].rng));
                    chkv($sformatf("f%0d_r%0d_c%0d_hi", frm, o.row, o.col), o.hi, mk(tbl[i].hi, tbl[i].rng));
                end
            end
        end
    endtask

    initial begin
        // frm, row, col, lo_ok, hi_ok, first, range, lo, mid, hi (per-lane values)
        tbl = '{
            '{0, 0, 1, 1'b1, 1'b1, 1'b1, 128,  0,  0,  0},
            '{0, 1, 1, 1'b1, 1'b1, 1'b0,   5,  7,  7,  7},
            '{0, 1, 2, 1'b1, 1'b1, 1'b0,   5,  7,  7,  7},
            '{1, 0, 0, 1'b0, 1'b1, 1'b1, 128,  0,  0,  0},
            '{1, 0, 2, 1'b1, 1'b1, 1'b1, 128,  0,  0,  0},
            '{1, 1, 0, 1'b0, 1'b1, 1'b0, 128,  0,  0,  1},
            '{1, 1, 1, 1'b1, 1'b1, 1'b0, 128,  0,  1,  2},
            '{1, 1, 3, 1'b1, 1'b0, 1'b0, 128,  2,  3,  0},
            '{1, 2, 1, 1'b1, 1'b1, 1'b0, 128, 10, 11, 12},
            '{1, 2, 3, 1'b1, 1'b0, 1'b0, 128, 12, 13,  0},
            '{2, 1, 0, 1'b0, 1'b1, 1'b0, 128,  0,  0,  1},
            '{2, 1, 2, 1'b1, 1'b1, 1'b0, 128,  1,  2,  3},
            '{4, 0, 1, 1'b1, 1'b1, 1'b1, 128,  0,  0,  0},
            '{4, 1, 1, 1'b1, 1'b1, 1'b0, 128,  0,  1,  2}
        };
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_wr_ready", bus.wr_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_frame_done", bus.frame_done, 0);
        chkv("reset_out_mid", bus.out_mid, '0);
        rst = 1'b1;

        // Range mask frame first, so the basic frame's row 0 sits over stale RAM.
        run_frame(4, 2, 5, 1'b0, 7, -1, -1, 0);
        run_frame(4, 3, 128, 1'b0, -1, -1, -1, 1);
        run_frame(4, 2, 128, 1'b1, -1, -1, -1, 2);

        run_frame(4, 3, 128, 1'b0, -1, 1, 2, 3);
        chk("pre_reset_out_valid_active", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        chk("midframe_reset_in_ready", bus.in_ready, 0);
        chk("midframe_reset_out_valid", bus.out_valid, 0);
        chk("midframe_reset_first_row", bus.out_first_row, 0);
        bus.in_valid = 1'b0;
        bus.wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_frame(4, 2, 128, 1'b0, -1, -1, -1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
